// File: rtl/uart_receive.sv
// UART receiver: 8 data bits, one parity bit, one stop bit; samples mid-bit.
// Accepted bytes land in data with a sticky ready flag; tx_o echoes the synchronized line.
module uart_receive #(
   parameter int CLKS_PER_BIT = 20,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   input  logic       reset_ready,
   output logic [7:0] data,
   output logic       ready,
   output logic       tx_o
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [2:0]      bit_idx, bit_idx_next;
   logic [7:0]      shift_reg, shift_next;
   logic            par_ok, par_ok_next;
   logic [7:0]      data_next;
   logic            ready_next;
   logic            load;
   logic            sync_a, rx_s, rx_prev;

   assign tx_o = rx_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a    <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         par_ok    <= 1'b0;
         data      <= '0;
         ready     <= 1'b0;
      end else begin
         sync_a    <= rx_i;
         rx_s      <= sync_a;
         rx_prev   <= rx_s;
         state     <= state_next;
         cnt       <= cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         par_ok    <= par_ok_next;
         data      <= data_next;
         ready     <= ready_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CW'(1);
      bit_idx_next = bit_idx;
      shift_next   = shift_reg;
      par_ok_next  = par_ok;
      data_next    = data;
      load         = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!rx_s && rx_prev) state_next = START;
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_next     = '0;
               bit_idx_next = '0;
               state_next   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_next     = '0;
               shift_next   = {rx_s, shift_reg[7:1]};
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = PARITY;
            end
         end
         PARITY: begin
            if (cnt == FULL_M1) begin
               cnt_next    = '0;
               par_ok_next = (rx_s == ((^shift_reg) ^ PARITY_ODD));
               state_next  = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_next   = '0;
               state_next = IDLE;
               if (rx_s && par_ok) begin
                  data_next = shift_reg;
                  load      = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A new byte outranks a simultaneous acknowledge.
   always_comb begin
      ready_next = ready;
      if (load)             ready_next = 1'b1;
      else if (reset_ready) ready_next = 1'b0;
   end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: directed and random frames checked against a frame-level model.
// A background monitor checks that tx_o trails rx_i by two clocks.
module tb_uart_receive;

   localparam int C = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_i = 1'b1;
   logic       reset_ready = 1'b0;
   logic [7:0] data;
   logic       ready;
   logic       tx_o;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_data = 8'h00;
   logic       exp_ready = 1'b0;

   uart_receive #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
      .clk(clk),
      .reset(reset),
      .rx_i(rx_i),
      .reset_ready(reset_ready),
      .data(data),
      .ready(ready),
      .tx_o(tx_o)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rx_i = 1'b1;
      reset_ready = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      check_eq("rst_data", {24'h0, data}, 32'h00);
      check_eq("rst_ready", {31'h0, ready}, 32'h0);
      check_eq("rst_tx", {31'h0, tx_o}, 32'h1);
      reset = 1'b0;
      exp_data = 8'h00;
      exp_ready = 1'b0;
   endtask

   // Sends one full frame; the model accepts it only with good parity and a 1 stop bit.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      logic [10:0] bits;
      bits = {stop, (^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (i == 10) begin
            check_eq("pre_stop_ready", {31'h0, ready}, {31'h0, exp_ready});
            check_eq("pre_stop_data", {24'h0, data}, {24'h0, exp_data});
         end
         rx_i = bits[i];
         repeat (C) tick();
      end
      if (!bad_par && stop) begin
         exp_data = b;
         exp_ready = 1'b1;
      end
      check_eq($sformatf("frame_%02h_ready", b), {31'h0, ready}, {31'h0, exp_ready});
      check_eq($sformatf("frame_%02h_data", b), {24'h0, data}, {24'h0, exp_data});
   endtask

   task automatic ack();
      reset_ready = 1'b1;
      tick();
      reset_ready = 1'b0;
      exp_ready = 1'b0;
      check_eq("ack_ready", {31'h0, ready}, 32'h0);
      check_eq("ack_data", {24'h0, data}, {24'h0, exp_data});
   endtask

   int   ecnt = 0;
   logic h1 = 1'b1, h2 = 1'b1;
   always @(negedge clk) begin
      if (reset) ecnt = 0;
      else begin
         if (ecnt >= 2) check_eq("echo", {31'h0, tx_o}, {31'h0, h2});
         ecnt++;
      end
      h2 = h1;
      h1 = rx_i;
   end

   initial begin
      logic [7:0] b;
      int kind;

      do_reset();
      idle(10);

      send_frame(8'h05, 1'b0, 1'b1);
      idle(50);
      check_eq("hold_ready", {31'h0, ready}, 32'h1);
      ack();
      idle(10);

      send_frame(8'h05, 1'b1, 1'b1);
      idle(2 * C);
      send_frame(8'hA5, 1'b0, 1'b0);
      idle(2 * C);

      rx_i = 1'b0;
      repeat (5) tick();
      idle(40);
      check_eq("glitch_ready", {31'h0, ready}, {31'h0, exp_ready});
      check_eq("glitch_data", {24'h0, data}, {24'h0, exp_data});
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(5);
      ack();

      send_frame(8'h12, 1'b0, 1'b1);
      send_frame(8'h34, 1'b0, 1'b1);
      idle(C);
      check_eq("b2b_data", {24'h0, data}, 32'h34);
      check_eq("b2b_ready", {31'h0, ready}, 32'h1);

      for (int n = 0; n < 25; n++) begin
         b = 8'($urandom_range(0, 255));
         kind = $urandom_range(0, 5);
         if ($urandom_range(0, 2) == 0) ack();
         if (kind == 0)      send_frame(b, 1'b1, 1'b1);
         else if (kind == 1) send_frame(b, 1'b0, 1'b0);
         else                send_frame(b, 1'b0, 1'b1);
         if (kind == 1) idle(C + $urandom_range(0, 25));
         else           idle($urandom_range(0, 25));
      end

      rx_i = 1'b0;
      repeat (3 * C) tick();
      do_reset();
      idle(20);
      send_frame(8'h5A, 1'b0, 1'b1);
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
